mem_arbiter: RTL

//  Shares the single main-memory line port between the fetch-stage I-cache miss path (read-only)
//  and the cache-stage D-cache miss/eviction path (read or write). Sits between both caches and
//  mem.v; one transaction at a time. D has priority, with a streak limit so fetch cannot starve.

---
 rtl/mem_arbiter_pkg.sv | 19 +
 rtl/mem_arbiter.sv | 128 ++++++++++++
 2 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the main-memory line-port arbiter: state encodings,
// default port widths and the grant-decision record.
package mem_arbiter_pkg;

    localparam int ARB_ADDR_W    = 32;
    localparam int ARB_LINE_BITS = 128;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_BUSY = 2'b01,
        ARB_RESP = 2'b10
    } arb_state_e;

    typedef struct packed {
        logic valid;
        logic to_d;
    } arb_grant_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the single memory line port between the I-cache miss path and the
// D-cache miss/eviction path; D wins unless it has starved a waiting I-fetch.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = ARB_ADDR_W,
    parameter int LINE_BITS    = ARB_LINE_BITS,
    parameter int MAX_D_STREAK = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_req,
    input  logic [ADDR_W-1:0]    i_addr,
    output logic                 i_ack,
    output logic [LINE_BITS-1:0] i_rdata,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [ADDR_W-1:0]    d_addr,
    input  logic [LINE_BITS-1:0] d_wdata,
    output logic                 d_ack,
    output logic [LINE_BITS-1:0] d_rdata,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [LINE_BITS-1:0] mem_wdata,
    input  logic [LINE_BITS-1:0] mem_rdata,
    input  logic                 mem_ack,
    output logic                 arb_busy,
    output logic                 arb_gnt_d
);

    localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    arb_state_e          state_r;
    logic [STREAK_W-1:0] streak_r;
    arb_grant_t          grant_s;

    // D normally wins; a pending I-fetch is forced through once D has used up its streak.
    function automatic arb_grant_t grant_sel(input logic i_pend, input logic d_pend,
                                             input logic streak_full);
        arb_grant_t g;
        g.valid = i_pend | d_pend;
        g.to_d  = d_pend & ~(i_pend & streak_full);
        return g;
    endfunction

    assign grant_s  = grant_sel(i_req, d_req, streak_r == STREAK_MAX);
    assign arb_busy = (state_r != ARB_IDLE);

    // Transaction FSM with grant latching, streak tracking and response capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ARB_IDLE;
            streak_r  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            arb_gnt_d <= 1'b0;
        end else begin
            case (state_r)
                ARB_IDLE: begin
                    if (grant_s.valid) begin
                        mem_req   <= 1'b1;
                        arb_gnt_d <= grant_s.to_d;
                        state_r   <= ARB_BUSY;
                        if (grant_s.to_d) begin
                            mem_we    <= d_we;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            // Only D wins that beat a waiting I count toward the streak.
                            if (!i_req) begin
                                streak_r <= '0;
                            end else if (streak_r != STREAK_MAX) begin
                                streak_r <= streak_r + STREAK_W'(1);
                            end else begin
                                streak_r <= streak_r;
                            end
                        end else begin
                            mem_we    <= 1'b0;
                            mem_addr  <= i_addr;
                            mem_wdata <= '0;
                            streak_r  <= '0;
                        end
                    end else begin
                        state_r <= ARB_IDLE;
                    end
                end
                ARB_BUSY: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state_r <= ARB_RESP;
                        if (arb_gnt_d) begin
                            d_ack <= 1'b1;
                            if (!mem_we) begin
                                d_rdata <= mem_rdata;
                            end else begin
                                d_rdata <= d_rdata;
                            end
                        end else begin
                            i_ack   <= 1'b1;
                            i_rdata <= mem_rdata;
                        end
                    end else begin
                        state_r <= ARB_BUSY;
                    end
                end
                ARB_RESP: begin
                    i_ack   <= 1'b0;
                    d_ack   <= 1'b0;
                    state_r <= ARB_IDLE;
                end
                default: begin
                    mem_req <= 1'b0;
                    i_ack   <= 1'b0;
                    d_ack   <= 1'b0;
                    state_r <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule
